// File: rtl/vc_drain_if.sv
// vc_drain_if: bundles the four class-FIFO read ports and the output-FIFO
// write port seen by the drain arbiter.
//   empty_0..3, data_in_0..3 : class FIFO status / read data (to arbiter)
//   pop_0..3                 : class FIFO pop strobes (from arbiter)
//   almost_full_out          : output FIFO back-pressure (to arbiter)
//   push_out, data_out, chan_out : output FIFO write port (from arbiter)
// master = FIFO side, slave = arbiter side.
interface vc_drain_if #(
  parameter int DATA_W = 12
);
  logic              empty_0, empty_1, empty_2, empty_3;
  logic [DATA_W-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic              pop_0, pop_1, pop_2, pop_3;
  logic              almost_full_out;
  logic              push_out;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        chan_out;

  modport master (
    output empty_0, empty_1, empty_2, empty_3,
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output almost_full_out,
    input  pop_0, pop_1, pop_2, pop_3,
    input  push_out, data_out, chan_out
  );

  modport slave (
    input  empty_0, empty_1, empty_2, empty_3,
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  almost_full_out,
    output pop_0, pop_1, pop_2, pop_3,
    output push_out, data_out, chan_out
  );
endinterface

// File: rtl/vc_drain_arbiter.sv
// vc_drain_arbiter: drains four class FIFOs into one output FIFO using a
// round-robin grant that skips empty channels and rotates after BURST
// consecutive pops. Each output word carries its source channel tag.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : vc_drain_if slave modport (class FIFO reads, output FIFO writes)
// Pop-to-push latency is two cycles: pop (p0) -> read data valid (p1) ->
// registered push (p2).
module vc_drain_arbiter #(
  parameter int DATA_W = 12,
  parameter int BURST  = 2
) (
  input  logic      clk,
  input  logic      reset,
  vc_drain_if.slave bus
);

  localparam logic [3:0] BURST_C = 4'(BURST);

  logic [3:0]        empty_v;
  logic [1:0]        ptr;
  logic [1:0]        ptr_nxt;
  logic [3:0]        burst_cnt;
  logic [3:0]        burst_nxt;
  logic              pop_v_p0;
  logic [1:0]        pop_ch_p0;
  logic [1:0]        cand;
  logic              rd_valid_p1;
  logic [1:0]        rd_chan_p1;
  logic [DATA_W-1:0] rd_data_p1;
  logic              push_p2;
  logic [DATA_W-1:0] data_p2;
  logic [1:0]        chan_p2;

  assign empty_v = {bus.empty_3, bus.empty_2, bus.empty_1, bus.empty_0};

  // Stage p0: grant decision and pop strobes
  always_comb begin
    ptr_nxt   = ptr;
    burst_nxt = burst_cnt;
    pop_v_p0  = 1'b0;
    pop_ch_p0 = ptr;
    cand      = ptr;
    if (!reset && !bus.almost_full_out) begin
      if (!empty_v[ptr] && (burst_cnt < BURST_C)) begin
        pop_v_p0  = 1'b1;
        burst_nxt = burst_cnt + 4'd1;
      end else begin
        // Walk from the farthest candidate (ptr itself) to the nearest
        // (ptr+1) so the nearest non-empty channel is the last one written.
        for (int i = 4; i >= 1; i--) begin
          cand = ptr + 2'(i);
          if (!empty_v[cand]) begin
            pop_v_p0  = 1'b1;
            pop_ch_p0 = cand;
          end
        end
        if (pop_v_p0) begin
          ptr_nxt   = pop_ch_p0;
          burst_nxt = 4'd1;
        end
      end
    end
  end

  assign bus.pop_0 = pop_v_p0 && (pop_ch_p0 == 2'd0);
  assign bus.pop_1 = pop_v_p0 && (pop_ch_p0 == 2'd1);
  assign bus.pop_2 = pop_v_p0 && (pop_ch_p0 == 2'd2);
  assign bus.pop_3 = pop_v_p0 && (pop_ch_p0 == 2'd3);

  // Stage p1: class FIFO read data for the channel popped last cycle
  always_comb begin
    case (rd_chan_p1)
      2'd0:    rd_data_p1 = bus.data_in_0;
      2'd1:    rd_data_p1 = bus.data_in_1;
      2'd2:    rd_data_p1 = bus.data_in_2;
      default: rd_data_p1 = bus.data_in_3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= 2'd0;
      burst_cnt   <= 4'd0;
      rd_valid_p1 <= 1'b0;
      rd_chan_p1  <= 2'd0;
      push_p2     <= 1'b0;
      data_p2     <= '0;
      chan_p2     <= 2'd0;
    end else begin
      ptr         <= ptr_nxt;
      burst_cnt   <= burst_nxt;
      rd_valid_p1 <= pop_v_p0;
      rd_chan_p1  <= pop_ch_p0;
      // Stage p2: registered write into the output FIFO
      push_p2     <= rd_valid_p1;
      if (rd_valid_p1) begin
        data_p2 <= rd_data_p1;
        chan_p2 <= rd_chan_p1;
      end
    end
  end

  assign bus.push_out = push_p2;
  assign bus.data_out = data_p2;
  assign bus.chan_out = chan_p2;

endmodule

// File: tb/tb_vc_drain_arbiter.sv
module tb_vc_drain_arbiter;
  localparam int DATA_W = 12;
  localparam int BURST  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic af = 1'b0;
  always #5 clk = ~clk;

  vc_drain_if #(.DATA_W(DATA_W)) bus ();
  vc_drain_arbiter #(.DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Class FIFO emulation
  logic [DATA_W-1:0] fq [4][$];
  logic              emp [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic [DATA_W-1:0] dq  [4] = '{12'h0, 12'h0, 12'h0, 12'h0};

  assign bus.empty_0 = emp[0];
  assign bus.empty_1 = emp[1];
  assign bus.empty_2 = emp[2];
  assign bus.empty_3 = emp[3];
  assign bus.data_in_0 = dq[0];
  assign bus.data_in_1 = dq[1];
  assign bus.data_in_2 = dq[2];
  assign bus.data_in_3 = dq[3];
  assign bus.almost_full_out = af;

  // Behavioural model state
  int                m_ptr = 0, m_cnt = 0;
  bit                m_rd_v = 0;
  int                m_rd_ch = 0;
  logic [DATA_W-1:0] m_rd_word = '0;
  bit                m_push = 0;
  logic [DATA_W-1:0] m_dout = '0;
  logic [1:0]        m_cout = '0;

  bit                e_v, e_keep, d_v;
  int                e_ch, d_ch;
  logic [DATA_W-1:0] e_word;
  bit                s_reset = 1'b1;
  bit                chk_en = 1'b0;
  int                cyc = 0;
  int                afp = 0;

  int                pop_log[$], pop_cyc[$], push_ch[$], push_cyc[$];
  logic [DATA_W-1:0] push_dat[$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Compare process: model decision + DUT output checks, away from posedge
  always @(negedge clk) begin
    logic [3:0] pv, ev;
    e_v = 0; e_keep = 0; e_ch = m_ptr; e_word = '0;
    if (!reset && !af) begin
      if (!emp[m_ptr] && m_cnt < BURST) begin
        e_v = 1; e_keep = 1; e_ch = m_ptr;
      end else begin
        for (int k = 1; k <= 4; k++)
          if (!e_v && !emp[(m_ptr + k) % 4]) begin
            e_v = 1; e_ch = (m_ptr + k) % 4;
          end
      end
    end
    if (e_v) e_word = fq[e_ch][0];
    pv = {bus.pop_3, bus.pop_2, bus.pop_1, bus.pop_0};
    ev = e_v ? 4'(1 << e_ch) : 4'd0;
    d_v = |pv;
    d_ch = pv[1] ? 1 : pv[2] ? 2 : pv[3] ? 3 : 0;
    s_reset = reset;
    if (chk_en) begin
      chk("pop", pv, ev);
      chk("push_out", bus.push_out, m_push);
      chk("data_out", bus.data_out, m_dout);
      chk("chan_out", bus.chan_out, m_cout);
      if (d_v) begin pop_log.push_back(d_ch); pop_cyc.push_back(cyc); end
      if (bus.push_out) begin
        push_ch.push_back(bus.chan_out);
        push_dat.push_back(bus.data_out);
        push_cyc.push_back(cyc);
        if (af) afp++;
      end
    end
  end

  // FIFO emulation and model state update after each edge
  always @(posedge clk) begin
    #2;
    cyc++;
    if (d_v && fq[d_ch].size() > 0) dq[d_ch] = fq[d_ch].pop_front();
    for (int k = 0; k < 4; k++) emp[k] = (fq[k].size() == 0);
    if (s_reset) begin
      m_ptr = 0; m_cnt = 0; m_rd_v = 0; m_rd_ch = 0;
      m_push = 0; m_dout = '0; m_cout = '0;
      chk_en = 1;
    end else begin
      m_push = m_rd_v;
      if (m_rd_v) begin m_dout = m_rd_word; m_cout = 2'(m_rd_ch); end
      m_rd_v = e_v; m_rd_ch = e_ch; m_rd_word = e_word;
      if (e_v) begin
        if (e_keep) m_cnt++;
        else begin m_ptr = e_ch; m_cnt = 1; end
      end
    end
  end

  task automatic clear_logs();
    pop_log.delete(); pop_cyc.delete();
    push_ch.delete(); push_dat.delete(); push_cyc.delete();
  endtask

  task automatic load(input int ch, input int n, input int base);
    for (int i = 0; i < n; i++) fq[ch].push_back(DATA_W'(base + i));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_fair[16] = '{0,0,1,1,2,2,3,3,0,0,1,1,2,2,3,3};
  int exp_bp[16]   = '{3,0,0,1,1,2,2,3,3,0,0,1,1,2,2,3};
  int exp_mid[4]   = '{1,3,3,3};
  int exp_mdat[4]  = '{12'h150, 12'h350, 12'h351, 12'h352};
  int exp_rst[4]   = '{0,0,1,1};
  int exp_rdat[4]  = '{12'h001, 12'h002, 12'h100, 12'h101};

  initial begin
    int bad, bad2;
    bit seen;
    // Reset with every FIFO non-empty
    for (int k = 0; k < 4; k++) load(k, 4, k * 256);
    step(3);
    chk("reset_pops", pop_log.size(), 0);
    chk("reset_pushes", push_ch.size(), 0);
    chk("reset_data_out", bus.data_out, 0);
    chk("reset_chan_out", bus.chan_out, 0);
    reset = 1'b0;

    // Fairness
    step(25);
    bad = 0; bad2 = 0;
    chk("fair_pop_count", pop_log.size(), 16);
    chk("fair_push_count", push_ch.size(), 16);
    if (pop_log.size() == 16 && push_ch.size() == 16) begin
      for (int j = 0; j < 16; j++) begin
        if (pop_log[j] != exp_fair[j] || push_ch[j] != exp_fair[j]) bad++;
        if (push_dat[j] != DATA_W'(exp_fair[j] * 256 + (j / 8) * 2 + (j % 2))) bad2++;
      end
      chk("fair_order_errors", bad, 0);
      chk("fair_data_errors", bad2, 0);
      chk("fair_push_span", push_cyc[15] - push_cyc[0], 15);
      chk("fair_latency", push_cyc[0] - pop_cyc[0], 2);
    end

    // Skip empty: only FIFO_2
    clear_logs();
    load(2, 5, 12'h200);
    step(10);
    chk("skip_pop_count", pop_log.size(), 5);
    chk("skip_push_count", push_ch.size(), 5);
    if (pop_log.size() == 5 && push_ch.size() == 5) begin
      bad = 0;
      for (int j = 0; j < 5; j++)
        if (pop_log[j] != 2 || push_ch[j] != 2 || push_dat[j] != DATA_W'(12'h200 + j)) bad++;
      chk("skip_errors", bad, 0);
      chk("skip_no_bubble", pop_cyc[4] - pop_cyc[0], 4);
    end

    // Mid-burst empty: prime ptr=1, then FIFO_1 one word, FIFO_3 three words
    load(1, 1, 12'h1AA);
    step(5);
    af = 1'b1;
    step(1);
    load(1, 1, 12'h150);
    load(3, 3, 12'h350);
    step(1);
    clear_logs();
    af = 1'b0;
    step(8);
    chk("mid_pop_count", pop_log.size(), 4);
    chk("mid_push_count", push_ch.size(), 4);
    if (pop_log.size() == 4 && push_ch.size() == 4) begin
      bad = 0;
      for (int j = 0; j < 4; j++)
        if (pop_log[j] != exp_mid[j] || push_ch[j] != exp_mid[j] ||
            push_dat[j] != DATA_W'(exp_mdat[j])) bad++;
      chk("mid_errors", bad, 0);
    end

    // Back-pressure during a stream
    clear_logs();
    for (int k = 0; k < 4; k++) load(k, 4, k * 256);
    step(3);
    af = 1'b1;
    afp = 0;
    step(4);
    chk("bp_inflight_pushes", afp, 2);
    af = 1'b0;
    step(20);
    chk("bp_pop_count", pop_log.size(), 16);
    if (pop_log.size() == 16) begin
      bad = 0;
      for (int j = 0; j < 16; j++) if (pop_log[j] != exp_bp[j]) bad++;
      chk("bp_order_errors", bad, 0);
    end

    // Reset one cycle after a pop of ch0
    load(0, 3, 12'h000);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.pop_0) seen = 1;
    end
    chk("rst_pop0_seen", seen, 1);
    step(1);
    reset = 1'b1;
    clear_logs();
    load(1, 2, 12'h100);
    step(1);
    reset = 1'b0;
    step(10);
    chk("rst_pop_count", pop_log.size(), 4);
    chk("rst_push_count", push_ch.size(), 4);
    if (pop_log.size() == 4 && push_ch.size() == 4) begin
      bad = 0;
      for (int j = 0; j < 4; j++)
        if (pop_log[j] != exp_rst[j] || push_ch[j] != exp_rst[j] ||
            push_dat[j] != DATA_W'(exp_rdat[j])) bad++;
      chk("rst_errors", bad, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vc_drain_arbiter.md
Name: vc_drain_arbiter

Overview:
- Downstream stage of the four-way round-robin distributor.
- Drains the four class FIFOs (FIFO_0..FIFO_3) that the distributor fills, and merges them into one output FIFO.
- Arbitration is round-robin, skips empty FIFOs, and caps the number of consecutive pops per class (bursts).
- Each output word is tagged with its source channel and pushed into the single output FIFO. Output back-pressure comes from that FIFO's almost_full.

Parameters:
- DATA_W, 12, width of FIFO data words.
- BURST, 2, maximum consecutive pops from one channel before the grant must rotate (legal range 1..15).

Ports:
- clk  input  1  single clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-high reset.
- empty_0..empty_3  input  1 each  empty flags of class FIFOs 0..3.
- data_in_0..data_in_3  input  DATA_W each  class FIFO read data; valid the cycle after that FIFO's pop.
- pop_0..pop_3  output  1 each  pop strobes to class FIFOs; combinational; at most one high per cycle.
- almost_full_out  input  1  almost_full of the output FIFO.
- push_out  output  1  registered push strobe to the output FIFO.
- data_out  output  DATA_W  registered data to the output FIFO.
- chan_out  output  2  registered source-channel tag accompanying data_out.

Behaviour:
- Reset (reset=1 at posedge clk):
  - push_out=0, data_out=0, chan_out=0.
  - ptr=0, burst_cnt=0, rd_valid=0, rd_chan=0.
  - pop_0..3 forced to 0 during every cycle in which reset=1.
- Internal state:
  - ptr[1:0]: current grant.
  - burst_cnt: pops issued to ptr since the grant was taken.
  - rd_valid, rd_chan: a pop was issued last cycle, and from which channel.
- Grant decision, combinational each cycle:
  - If almost_full_out=1, no pop is issued.
  - Else if empty_ptr=0 and burst_cnt<BURST, pop ptr and increment burst_cnt.
  - Else search ptr+1, ptr+2, ptr+3, ptr (mod 4) for the first non-empty channel c.
    - If found: pop c; at the edge ptr<=c and burst_cnt<=1.
    - If none found: no pop; ptr and burst_cnt hold.
- Burst expiry:
  - If the search after expiry lands on ptr itself (all other channels empty), ptr keeps the grant and burst_cnt restarts at 1.
  - No idle cycle is inserted on a grant change.
- Pipeline:
  - Pop at cycle N captures rd_valid=1, rd_chan=c at the end of cycle N.
  - At the end of cycle N+1: data_out<=data_in_c, chan_out<=c, push_out<=1.
  - Pop-to-push_out latency is 2 cycles.
  - With no valid read, push_out<=0, and data_out/chan_out hold their last value.
- Throughput: one word per cycle sustained while any FIFO is non-empty and almost_full_out=0.
- Back-pressure:
  - almost_full_out blocks new pops in the same cycle.
  - Up to 2 words already in flight are still pushed after almost_full_out rises.
  - The output FIFO's almost_full threshold therefore leaves at least 2 free entries.
  - Pops resume in the first cycle almost_full_out=0. Arbitration state (ptr, burst_cnt) is preserved across the stall.
- Empty handling:
  - Class FIFOs update empty at the edge following a pop, so back-to-back pops of a one-entry FIFO cannot occur.
  - A granted channel that goes empty mid-burst loses the grant immediately; the search runs the same cycle.
- Reset mid-operation: in-flight reads are discarded (rd_valid cleared); no push_out follows the reset.
- Invariant: pop_0..3 is one-hot or zero; never a pop on a channel whose empty=1.

Test Plan:
- Reset: hold reset=1 for 3 cycles with all FIFOs non-empty -> pops all 0 and push_out=0 throughout; data_out=0, chan_out=0.
- Fairness, BURST=2: all four FIFOs hold 4 words (ch k words = 0xk00..0xk03), almost_full_out=0.
  - Required pop order: 0,0,1,1,2,2,3,3,0,0,1,1,2,2,3,3.
  - push_out high 16 consecutive cycles starting 2 cycles after the first pop; chan_out and data_out match each word.
- Skip empty: only FIFO_2 holds 5 words -> pop_2 every cycle for 5 cycles (burst restarts, no bubbles); 5 pushes with chan_out=2.
- Back-pressure: raise almost_full_out during a stream -> no pop that cycle; exactly 2 further pushes, then push_out=0.
  - Dropping almost_full_out resumes on the same ptr with the same burst_cnt.
- Mid-burst empty: FIFO_1 has 1 word, FIFO_3 has 3 words, ptr=1 -> pops 1,3,3,3; chan_out sequence 1,3,3,3.
- Reset mid-stream: assert reset 1 cycle after a pop of ch0 -> no push_out for that word; after release, arbitration restarts from ch0.
